// File: rtl/vid_out_window_stencil.sv
`default_nettype none
// ============================================================================
// Module : vid_out_window_stencil
// Output stencil that mutes blanking, paints active pixels outside a
// per-frame rectangular window with a border colour, and delays everything.
// Rev    : 1.0  initial release
// ============================================================================
module vid_out_window_stencil #(
    parameter int RGB_hbit    = 7,
    parameter int PIPE_DLY    = 1,
    parameter int CNT_BITS    = 12,
    parameter int PIXEL_PHASE = 0,
    parameter int HS_invert   = 0,
    parameter int VS_invert   = 0
) (
    input  logic                pclk,
    input  logic                reset,
    input  logic [3:0]          pc_ena,
    input  logic                hde_in,
    input  logic                vde_in,
    input  logic                hs_in,
    input  logic                vs_in,
    input  logic [RGB_hbit:0]   r_in,
    input  logic [RGB_hbit:0]   g_in,
    input  logic [RGB_hbit:0]   b_in,
    input  logic                win_enable,
    input  logic [CNT_BITS-1:0] win_x0,
    input  logic [CNT_BITS-1:0] win_x1,
    input  logic [CNT_BITS-1:0] win_y0,
    input  logic [CNT_BITS-1:0] win_y1,
    input  logic [RGB_hbit:0]   border_r,
    input  logic [RGB_hbit:0]   border_g,
    input  logic [RGB_hbit:0]   border_b,
    output logic                hde_out,
    output logic                vde_out,
    output logic                hs_out,
    output logic                vs_out,
    output logic [RGB_hbit:0]   r_out,
    output logic [RGB_hbit:0]   g_out,
    output logic [RGB_hbit:0]   b_out,
    output logic                vid_de_out
);

    localparam logic [3:0]          c_phase   = 4'(PIXEL_PHASE);
    localparam logic [CNT_BITS-1:0] c_cnt_max = '1;
    localparam logic [CNT_BITS-1:0] c_cnt_one = CNT_BITS'(1);
    localparam logic                c_hs_inv  = 1'(HS_invert);
    localparam logic                c_vs_inv  = 1'(VS_invert);

    logic w_step;
    assign w_step = (pc_ena == c_phase);

    logic [CNT_BITS-1:0] r_h_cnt;
    logic [CNT_BITS-1:0] r_v_cnt;
    logic                r_hde_prev;

    always_ff @(posedge pclk) begin
        if (reset) begin
            r_h_cnt    <= '0;
            r_v_cnt    <= '0;
            r_hde_prev <= 1'b0;
        end else if (w_step) begin
            r_hde_prev <= hde_in;
            if (!hde_in)
                r_h_cnt <= '0;
            else if (r_h_cnt != c_cnt_max)
                r_h_cnt <= r_h_cnt + c_cnt_one;
            // A line ends on the first blank step after an active one.
            if (!vde_in)
                r_v_cnt <= '0;
            else if (r_hde_prev && !hde_in && (r_v_cnt != c_cnt_max))
                r_v_cnt <= r_v_cnt + c_cnt_one;
        end
    end

    logic                r_sh_en;
    logic [CNT_BITS-1:0] r_sh_x0, r_sh_x1, r_sh_y0, r_sh_y1;
    logic [RGB_hbit:0]   r_sh_br, r_sh_bg, r_sh_bb;

    // Window settings only follow the inputs during vertical blank.
    always_ff @(posedge pclk) begin
        if (reset) begin
            r_sh_en <= 1'b0;
            r_sh_x0 <= '0;
            r_sh_x1 <= '0;
            r_sh_y0 <= '0;
            r_sh_y1 <= '0;
            r_sh_br <= '0;
            r_sh_bg <= '0;
            r_sh_bb <= '0;
        end else if (w_step && !vde_in) begin
            r_sh_en <= win_enable;
            r_sh_x0 <= win_x0;
            r_sh_x1 <= win_x1;
            r_sh_y0 <= win_y0;
            r_sh_y1 <= win_y1;
            r_sh_br <= border_r;
            r_sh_bg <= border_g;
            r_sh_bb <= border_b;
        end
    end

    logic              w_active;
    logic              w_inside;
    logic [RGB_hbit:0] w_r, w_g, w_b;

    assign w_active = hde_in & vde_in;
    assign w_inside = (r_h_cnt >= r_sh_x0) && (r_h_cnt <= r_sh_x1) &&
                      (r_v_cnt >= r_sh_y0) && (r_v_cnt <= r_sh_y1);

    always_comb begin
        w_r = '0;
        w_g = '0;
        w_b = '0;
        if (w_active) begin
            if (!r_sh_en || w_inside) begin
                w_r = r_in;
                w_g = g_in;
                w_b = b_in;
            end else begin
                w_r = r_sh_br;
                w_g = r_sh_bg;
                w_b = r_sh_bb;
            end
        end
    end

    logic              r_hde [PIPE_DLY];
    logic              r_vde [PIPE_DLY];
    logic              r_de  [PIPE_DLY];
    logic              r_hs  [PIPE_DLY];
    logic              r_vs  [PIPE_DLY];
    logic [RGB_hbit:0] r_r   [PIPE_DLY];
    logic [RGB_hbit:0] r_g   [PIPE_DLY];
    logic [RGB_hbit:0] r_b   [PIPE_DLY];

    always_ff @(posedge pclk) begin
        if (reset) begin
            for (int i = 0; i < PIPE_DLY; i++) begin
                r_hde[i] <= 1'b0;
                r_vde[i] <= 1'b0;
                r_de[i]  <= 1'b0;
                r_hs[i]  <= c_hs_inv;
                r_vs[i]  <= c_vs_inv;
                r_r[i]   <= '0;
                r_g[i]   <= '0;
                r_b[i]   <= '0;
            end
        end else if (w_step) begin
            r_hde[0] <= hde_in;
            r_vde[0] <= vde_in;
            r_de[0]  <= w_active;
            r_hs[0]  <= hs_in ^ c_hs_inv;
            r_vs[0]  <= vs_in ^ c_vs_inv;
            r_r[0]   <= w_r;
            r_g[0]   <= w_g;
            r_b[0]   <= w_b;
            for (int i = 1; i < PIPE_DLY; i++) begin
                r_hde[i] <= r_hde[i-1];
                r_vde[i] <= r_vde[i-1];
                r_de[i]  <= r_de[i-1];
                r_hs[i]  <= r_hs[i-1];
                r_vs[i]  <= r_vs[i-1];
                r_r[i]   <= r_r[i-1];
                r_g[i]   <= r_g[i-1];
                r_b[i]   <= r_b[i-1];
            end
        end
    end

    assign hde_out    = r_hde[PIPE_DLY-1];
    assign vde_out    = r_vde[PIPE_DLY-1];
    assign vid_de_out = r_de[PIPE_DLY-1];
    assign hs_out     = r_hs[PIPE_DLY-1];
    assign vs_out     = r_vs[PIPE_DLY-1];
    assign r_out      = r_r[PIPE_DLY-1];
    assign g_out      = r_g[PIPE_DLY-1];
    assign b_out      = r_b[PIPE_DLY-1];

endmodule
`default_nettype wire

// File: tb/tb_vid_out_window_stencil.sv
`default_nettype none
// ============================================================================
// Module : tb_vid_out_window_stencil
// Bench for vid_out_window_stencil: 1-step and 4-step instances, frame model.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_vid_out_window_stencil;

    localparam int H_ACT = 32;
    localparam int H_BLK = 8;
    localparam int V_ACT = 12;
    localparam int V_BLK = 3;

    logic        pclk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  pc_ena = 4'd0;
    logic        hde_in = 1'b0, vde_in = 1'b0, hs_in = 1'b0, vs_in = 1'b0;
    logic [7:0]  r_in = '0, g_in = '0, b_in = '0;
    logic        win_enable = 1'b0;
    logic [11:0] win_x0 = '0, win_x1 = '0, win_y0 = '0, win_y1 = '0;
    logic [7:0]  border_r = 8'h12, border_g = 8'h34, border_b = 8'h56;

    logic       a_hde, a_vde, a_hs, a_vs, a_de;
    logic [7:0] a_r, a_g, a_b;
    logic       d_hde, d_vde, d_hs, d_vs, d_de;
    logic [7:0] d_r, d_g, d_b;

    vid_out_window_stencil #(.RGB_hbit(7), .PIPE_DLY(1), .CNT_BITS(12),
        .PIXEL_PHASE(0), .HS_invert(0), .VS_invert(0)) dut1 (
        .pclk(pclk), .reset(reset), .pc_ena(pc_ena),
        .hde_in(hde_in), .vde_in(vde_in), .hs_in(hs_in), .vs_in(vs_in),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .win_enable(win_enable), .win_x0(win_x0), .win_x1(win_x1),
        .win_y0(win_y0), .win_y1(win_y1),
        .border_r(border_r), .border_g(border_g), .border_b(border_b),
        .hde_out(a_hde), .vde_out(a_vde), .hs_out(a_hs), .vs_out(a_vs),
        .r_out(a_r), .g_out(a_g), .b_out(a_b), .vid_de_out(a_de));

    vid_out_window_stencil #(.RGB_hbit(7), .PIPE_DLY(4), .CNT_BITS(12),
        .PIXEL_PHASE(0), .HS_invert(1), .VS_invert(0)) dut4 (
        .pclk(pclk), .reset(reset), .pc_ena(pc_ena),
        .hde_in(hde_in), .vde_in(vde_in), .hs_in(hs_in), .vs_in(vs_in),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .win_enable(win_enable), .win_x0(win_x0), .win_x1(win_x1),
        .win_y0(win_y0), .win_y1(win_y1),
        .border_r(border_r), .border_g(border_g), .border_b(border_b),
        .hde_out(d_hde), .vde_out(d_vde), .hs_out(d_hs), .vs_out(d_vs),
        .r_out(d_r), .g_out(d_g), .b_out(d_b), .vid_de_out(d_de));

    always #5 pclk = ~pclk;

    // hs/vs are kept un-inverted in the model; each instance applies its own polarity.
    typedef struct packed {
        logic       hde, vde, hs, vs;
        logic [7:0] r, g, b;
    } stage_t;

    stage_t      hist [8];
    logic        m_en;
    logic [11:0] m_x0, m_x1, m_y0, m_y1;
    logic [7:0]  m_br, m_bg, m_bb;

    int  checks = 0, failures = 0;
    bit  running = 1'b0;
    int  step_no = 0, rise_step = -1, lat1 = -1, lat4 = -1;
    int  cnt_de, cnt_pass, cnt_border, cnt_blank_nz;
    bit  prev_act = 1'b0;

    task automatic clear_model();
        for (int i = 0; i < 8; i++) hist[i] = '0;
        m_en = 1'b0;
        m_x0 = '0; m_x1 = '0; m_y0 = '0; m_y1 = '0;
        m_br = '0; m_bg = '0; m_bb = '0;
    endtask

    function automatic stage_t model_stage(int x, int y);
        stage_t s;
        s = '0;
        s.hde = hde_in; s.vde = vde_in; s.hs = hs_in; s.vs = vs_in;
        if (hde_in && vde_in) begin
            if (!m_en || (x >= int'(m_x0) && x <= int'(m_x1) &&
                          y >= int'(m_y0) && y <= int'(m_y1))) begin
                s.r = r_in; s.g = g_in; s.b = b_in;
            end else begin
                s.r = m_br; s.g = m_bg; s.b = m_bb;
            end
        end
        return s;
    endfunction

    task automatic check_dut(string name, stage_t e, logic hs_inv,
                             logic hde, logic vde, logic de, logic hs, logic vs,
                             logic [7:0] r, logic [7:0] g, logic [7:0] b);
        logic [28:0] act, exp;
        exp = {e.hde, e.vde, e.hde & e.vde, e.hs ^ hs_inv, e.vs, e.r, e.g, e.b};
        act = {hde, vde, de, hs, vs, r, g, b};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t step=%0d actual=%h expected=%h",
                     name, $time, step_no, act, exp);
        end
    endtask

    task automatic lit(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Every cycle, stepping or not, both instances must match the model.
    initial begin
        forever begin
            @(negedge pclk);
            if (running) begin
                check_dut("dut1_out", hist[0], 1'b0, a_hde, a_vde, a_de, a_hs, a_vs, a_r, a_g, a_b);
                check_dut("dut4_out", hist[3], 1'b1, d_hde, d_vde, d_de, d_hs, d_vs, d_r, d_g, d_b);
            end
        end
    end

    task automatic tally();
        if (a_de) begin
            cnt_de++;
            if (a_b == 8'hFF) cnt_pass++;
            else if ({a_r, a_g, a_b} == {border_r, border_g, border_b}) cnt_border++;
        end else if ({a_r, a_g, a_b} != 24'd0) begin
            cnt_blank_nz++;
        end
        if (rise_step >= 0 && lat1 < 0 && a_de) lat1 = step_no - rise_step + 1;
        if (rise_step >= 0 && lat4 < 0 && d_de) lat4 = step_no - rise_step + 1;
    endtask

    task automatic pix(logic hde, logic vde, logic hs, logic vs, int x, int y);
        hde_in = hde; vde_in = vde; hs_in = hs; vs_in = vs;
        r_in = 8'(x * 3); g_in = 8'(y); b_in = 8'hFF;
        pc_ena = 4'd0;
        @(posedge pclk); #1;
        step_no++;
        if (hde && vde && !prev_act && rise_step < 0) rise_step = step_no;
        prev_act = hde && vde;
        for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = model_stage(x, y);
        if (!vde) begin
            m_en = win_enable;
            m_x0 = win_x0; m_x1 = win_x1; m_y0 = win_y0; m_y1 = win_y1;
            m_br = border_r; m_bg = border_g; m_bb = border_b;
        end
        @(negedge pclk);
        tally();
        pc_ena = 4'd1;
        @(posedge pclk); #1 pc_ena = 4'd2;
        @(posedge pclk); #1 pc_ena = 4'd3;
        @(posedge pclk); #1;
    endtask

    task automatic do_reset(int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            pc_ena = 4'(i);
            @(posedge pclk); #1;
            clear_model();
        end
        reset = 1'b0;
    endtask

    task automatic frame(int rst_line, int rst_col, int chg_line, logic [11:0] chg_x0);
        cnt_de = 0; cnt_pass = 0; cnt_border = 0; cnt_blank_nz = 0;
        rise_step = -1; lat1 = -1; lat4 = -1;
        for (int l = 0; l < V_BLK; l++)
            for (int c = 0; c < H_ACT + H_BLK; c++)
                pix(c < H_ACT, 1'b0, (c >= H_ACT + 2) && (c < H_ACT + 5), l == 0, c, l);
        for (int y = 0; y < V_ACT; y++) begin
            if (y == chg_line) win_x0 = chg_x0;
            for (int c = 0; c < H_ACT + H_BLK; c++) begin
                if (y == rst_line && c == rst_col) do_reset(3);
                pix(c < H_ACT, 1'b1, (c >= H_ACT + 2) && (c < H_ACT + 5), 1'b0, c, y);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        clear_model();
        reset = 1'b1;
        @(posedge pclk); #1;
        running = 1'b1;
        @(posedge pclk); #1;
        lit("rst_dut1_r", int'(a_r), 0);
        lit("rst_dut1_de", int'({a_hde, a_vde, a_de}), 0);
        lit("rst_dut1_hs", int'(a_hs), 0);
        lit("rst_dut4_hs", int'(d_hs), 1);
        lit("rst_dut4_vs", int'(d_vs), 0);
        reset = 1'b0;

        win_x0 = 12'd10; win_x1 = 12'd19; win_y0 = 12'd5; win_y1 = 12'd6;
        win_enable = 1'b0;
        frame(-1, -1, -1, 12'd0);
        lit("mute_de_count", cnt_de, H_ACT * V_ACT);
        lit("mute_pass_count", cnt_pass, H_ACT * V_ACT);
        lit("mute_blank_nonzero", cnt_blank_nz, 0);
        lit("latency_dut1", lat1, 1);
        lit("latency_dut4", lat4, 4);

        win_enable = 1'b1;
        frame(-1, -1, -1, 12'd0);
        lit("crop_pass_count", cnt_pass, 20);
        lit("crop_border_count", cnt_border, H_ACT * V_ACT - 20);
        lit("crop_blank_nonzero", cnt_blank_nz, 0);

        win_x0 = 12'd20; win_x1 = 12'd10;
        frame(-1, -1, -1, 12'd0);
        lit("empty_pass_count", cnt_pass, 0);
        lit("empty_border_count", cnt_border, H_ACT * V_ACT);
        lit("empty_de_count", cnt_de, H_ACT * V_ACT);

        win_x0 = 12'd10; win_x1 = 12'd19;
        frame(-1, -1, 6, 12'd0);
        lit("shadow_cur_frame_pass", cnt_pass, 20);
        frame(-1, -1, -1, 12'd0);
        lit("shadow_next_frame_pass", cnt_pass, 40);

        win_x0 = 12'd10;
        frame(3, 10, -1, 12'd0);
        lit("reset_frame_pass", cnt_pass, 278);
        lit("reset_frame_border", cnt_border, 106);

        frame(-1, -1, -1, 12'd0);
        lit("after_reset_crop_pass", cnt_pass, 20);

        running = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
